trap_sequencer: RTL and testbench

- Machine-mode trap controller sitting between the exception detector, the CSR file and the fetch/PC unit.
- Takes synchronous exception reports, pending interrupts and MRET requests, then picks one winner.
- Sequences pipeline flush, the mepc/mcause/mtval/mstatus CSR writes, and the PC redirect to the handler or return address.

---
 rtl/trap_pkg.sv | 35 +++
 rtl/trap_prio_enc.sv | 73 +++++++
 rtl/trap_sequencer.sv | 174 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared states, CSR addresses, cause codes and mstatus bit indices for the trap sequencer
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_TVAL,
        ST_W_STATUS,
        ST_W_STATUS_RET,
        ST_REDIRECT
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [3:0] EXC_INST_MISALIGNED  = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL_INST     = 4'd2;
    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd5;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - combinational trap source arbitration and cause/epc/tval formation
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_cause,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic            i_mret_req,
    input  logic            i_instr_done,
    input  logic [XLEN-1:0] i_next_pc,
    input  logic [XLEN-1:0] i_mip,
    input  logic [XLEN-1:0] i_mie,
    input  logic            i_glob_ie,
    output logic            o_accept,
    output logic            o_is_mret,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_tval
);

    logic [XLEN-1:0] w_pend;
    logic            w_irq_ok;
    logic [3:0]      w_irq_code;
    logic            w_irq_hit;
    logic            w_unused_pend;

    assign w_pend   = i_mip & i_mie;
    assign w_irq_ok = i_instr_done & i_glob_ie;
    assign w_unused_pend = ^{w_pend[XLEN-1:12], w_pend[10:8], w_pend[6:4], w_pend[2:0]};

    // External beats software beats timer.
    always_comb begin
        w_irq_hit  = 1'b0;
        w_irq_code = 4'd0;
        if (w_irq_ok) begin
            if (w_pend[IRQ_MEI]) begin
                w_irq_hit  = 1'b1;
                w_irq_code = IRQ_MEI;
            end else if (w_pend[IRQ_MSI]) begin
                w_irq_hit  = 1'b1;
                w_irq_code = IRQ_MSI;
            end else if (w_pend[IRQ_MTI]) begin
                w_irq_hit  = 1'b1;
                w_irq_code = IRQ_MTI;
            end
        end
    end

    always_comb begin
        o_accept  = 1'b0;
        o_is_mret = 1'b0;
        o_cause   = '0;
        o_epc     = '0;
        o_tval    = '0;
        if (i_exc_valid) begin
            o_accept = 1'b1;
            o_cause  = {{(XLEN-4){1'b0}}, i_exc_cause};
            o_epc    = i_exc_pc;
            o_tval   = i_exc_tval;
        end else if (i_mret_req) begin
            o_accept  = 1'b1;
            o_is_mret = 1'b1;
        end else if (w_irq_hit) begin
            o_accept = 1'b1;
            o_cause  = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
            o_epc    = i_next_pc;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap/MRET sequencer (flush, CSR writes, PC redirect); TRAP_VECTORED_EN enables vectored interrupts
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_req,
    input  logic            instr_done,
    input  logic [XLEN-1:0] next_pc,
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            flush_ack,
    output logic            flush_req,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    output logic            busy,
    output logic            trap_taken
);

    localparam int CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic            r_is_mret;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;

    logic            w_accept;
    logic            w_is_mret;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_epc;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_status_trap;
    logic [XLEN-1:0] w_status_ret;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_trap_target;

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_exc_valid  (exc_valid),
        .i_exc_cause  (exc_cause),
        .i_exc_pc     (exc_pc),
        .i_exc_tval   (exc_tval),
        .i_mret_req   (mret_req),
        .i_instr_done (instr_done),
        .i_next_pc    (next_pc),
        .i_mip        (mip),
        .i_mie        (mie),
        .i_glob_ie    (mstatus[MSTATUS_MIE]),
        .o_accept     (w_accept),
        .o_is_mret    (w_is_mret),
        .o_cause      (w_cause),
        .o_epc        (w_epc),
        .o_tval       (w_tval)
    );

    always_comb begin
        w_status_trap = mstatus;
        w_status_trap[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
        w_status_trap[MSTATUS_MIE]  = 1'b0;
        w_status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        w_status_ret = mstatus;
        w_status_ret[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
        w_status_ret[MSTATUS_MPIE] = 1'b1;
    end

    assign w_trap_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Vectored mode offsets interrupts only; exceptions always land on the base.
    assign w_trap_target = ((mtvec[1:0] == 2'b01) && r_cause[XLEN-1])
                         ? (w_trap_base + (XLEN'(r_cause[3:0]) << 2))
                         : w_trap_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
    assign w_trap_target = w_trap_base;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_is_mret   <= 1'b0;
            r_cause     <= '0;
            r_epc       <= '0;
            r_tval      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 1'b1 : '0;
            if (r_state == ST_IDLE && w_accept) begin
                r_is_mret <= w_is_mret;
                r_cause   <= w_cause;
                r_epc     <= w_epc;
                r_tval    <= w_tval;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush_req   = 1'b0;
        csr_we      = 1'b0;
        csr_waddr   = 12'h000;
        csr_wdata   = '0;
        pc_load     = 1'b0;
        pc_target   = '0;
        trap_taken  = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack || (r_flush_cnt == FLUSH_LAST))
                    w_state_nxt = r_is_mret ? ST_W_STATUS_RET : ST_W_EPC;
            end
            ST_W_EPC: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MEPC;
                csr_wdata   = {r_epc[XLEN-1:2], 2'b00};
                w_state_nxt = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MCAUSE;
                csr_wdata   = r_cause;
                w_state_nxt = ST_W_TVAL;
            end
            ST_W_TVAL: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MTVAL;
                csr_wdata   = r_tval;
                w_state_nxt = ST_W_STATUS;
            end
            ST_W_STATUS: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MSTATUS;
                csr_wdata   = w_status_trap;
                w_state_nxt = ST_REDIRECT;
            end
            ST_W_STATUS_RET: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MSTATUS;
                csr_wdata   = w_status_ret;
                w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_load     = 1'b1;
                pc_target   = r_is_mret ? {mepc_in[XLEN-1:2], 2'b00} : w_trap_target;
                trap_taken  = ~r_is_mret;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer CSR write and redirect sequences
module tb_trap_sequencer;

    logic        clk;
    logic        resetn;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval, next_pc, mip, mie, mstatus, mtvec, mepc_in;
    logic        mret_req, instr_done, flush_ack;
    logic        flush_req, csr_we, pc_load, busy, trap_taken;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, pc_target;

    typedef struct {
        logic        is_pc;
        logic [11:0] addr;
        logic [31:0] data;
        logic        trap;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ack_delay = 0;
    int   req_cycles = 0;

    trap_sequencer #(.XLEN(32), .FLUSH_TIMEOUT(15)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_pc     (exc_pc),
        .exc_tval   (exc_tval),
        .mret_req   (mret_req),
        .instr_done (instr_done),
        .next_pc    (next_pc),
        .mip        (mip),
        .mie        (mie),
        .mstatus    (mstatus),
        .mtvec      (mtvec),
        .mepc_in    (mepc_in),
        .flush_ack  (flush_ack),
        .flush_req  (flush_req),
        .csr_we     (csr_we),
        .csr_waddr  (csr_waddr),
        .csr_wdata  (csr_wdata),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .busy       (busy),
        .trap_taken (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_csr(input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.is_pc = 1'b0; e.addr = a; e.data = d; e.trap = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_pc(input logic [31:0] t, input logic tr);
        exp_t e;
        e.is_pc = 1'b1; e.addr = 12'h000; e.data = t; e.trap = tr;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] st,
                             input logic [31:0] tgt);
        push_csr(12'h341, epc);
        push_csr(12'h342, cause);
        push_csr(12'h343, tval);
        push_csr(12'h300, st);
        push_pc(tgt, 1'b1);
    endtask

    // Monitor: every CSR write or redirect must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn) begin
            if (csr_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_csr_we", {20'h0, csr_waddr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("csr_kind", {31'h0, e.is_pc}, 32'h0);
                    chk("csr_waddr", {20'h0, csr_waddr}, {20'h0, e.addr});
                    chk("csr_wdata", csr_wdata, e.data);
                end
            end
            if (pc_load) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pc_load", pc_target, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pc_kind", {31'h0, e.is_pc}, 32'h1);
                    chk("pc_target", pc_target, e.data);
                    chk("trap_taken", {31'h0, trap_taken}, {31'h0, e.trap});
                end
            end
            if (trap_taken && !pc_load)
                chk("trap_taken_alone", 32'h1, 32'h0);
        end
    end

    // Pipeline model: acknowledges the flush ack_delay cycles after it is requested (-1 = never).
    initial begin
        flush_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (flush_req) begin
                flush_ack = (req_cycles == ack_delay);
                req_cycles++;
            end else begin
                flush_ack  = 1'b0;
                req_cycles = 0;
            end
        end
    end

    task automatic clear_reqs();
        exc_valid  = 1'b0;
        mret_req   = 1'b0;
        instr_done = 1'b0;
        mip        = 32'h0;
    endtask

    // Runs from the accept cycle until pc_load; poke re-asserts requests mid-sequence.
    task automatic go(input int poke, output int lat, output int fl);
        lat = 0;
        fl  = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            clear_reqs();
            lat++;
            if (lat == poke) begin
                exc_valid = 1'b1;
                mret_req  = 1'b1;
            end
            if (flush_req) fl++;
            if (pc_load) break;
        end
        if (!pc_load) chk("pc_load_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        chk("idle_after", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int lat, fl, busy_cnt;
        resetn = 1'b1;
        clear_reqs();
        exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0; next_pc = 32'h0;
        mie = 32'h0; mstatus = 32'h8; mtvec = 32'h80; mepc_in = 32'h0;
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ctl", {27'h0, flush_req, csr_we, pc_load, busy, trap_taken}, 32'h0);
        chk("reset_waddr", {20'h0, csr_waddr}, 32'h0);
        chk("reset_wdata", csr_wdata, 32'h0);
        chk("reset_target", pc_target, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Store misaligned, ack in third flush cycle.
        ack_delay = 2;
        push_trap(32'h100, 32'h5, 32'h203, 32'h1880, 32'h80);
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h100; exc_tval = 32'h203;
        go(0, lat, fl);
        chk("exc_latency", lat, 8);
        chk("exc_flush_cycles", fl, 3);

        // MEI beats MTI, minimum trap latency.
        ack_delay = 0;
        push_trap(32'h44, 32'h8000_000B, 32'h0, 32'h1880, 32'h80);
        mip = 32'h880; mie = 32'h880; instr_done = 1'b1; next_pc = 32'h44;
        go(0, lat, fl);
        chk("irq_latency", lat, 6);

        // MSI beats MTI.
        push_trap(32'h48, 32'h8000_0003, 32'h0, 32'h1880, 32'h80);
        mip = 32'h88; mie = 32'h88; instr_done = 1'b1; next_pc = 32'h48;
        go(0, lat, fl);

        // Global MIE clear: pending MTI ignored, exception still taken with epc low bits masked.
        mstatus = 32'h0; mie = 32'h80;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            mip = 32'h80; instr_done = 1'b1;
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        chk("mie0_no_trap", busy_cnt, 0);
        push_trap(32'h200, 32'h0, 32'h201, 32'h1800, 32'h80);
        exc_valid = 1'b1; exc_cause = 4'd0; exc_pc = 32'h202; exc_tval = 32'h201;
        go(0, lat, fl);

        // MRET with MPIE=1, minimum latency.
        mstatus = 32'h80; mepc_in = 32'h104;
        push_csr(12'h300, 32'h88);
        push_pc(32'h104, 1'b0);
        mret_req = 1'b1;
        go(0, lat, fl);
        chk("mret_latency", lat, 3);

        // MRET with MPIE=0 and misaligned mepc.
        mstatus = 32'h0; mepc_in = 32'h10B;
        push_csr(12'h300, 32'h80);
        push_pc(32'h108, 1'b0);
        mret_req = 1'b1;
        go(0, lat, fl);

        // Exception wins over simultaneous MRET and interrupt.
        mstatus = 32'h8; mie = 32'h888;
        push_trap(32'h700, 32'h2, 32'h0, 32'h1880, 32'h80);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h700; exc_tval = 32'h0;
        mret_req = 1'b1; mip = 32'h888; instr_done = 1'b1;
        go(0, lat, fl);

        // Flush never acknowledged; requests during the sequence are dropped.
        ack_delay = -1;
        push_trap(32'h300, 32'h2, 32'h0, 32'h1880, 32'h80);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h300;
        go(5, lat, fl);
        chk("timeout_flush_cycles", fl, 15);
        chk("timeout_latency", lat, 20);

        // Vector mode: interrupts offset by 4*code, exceptions to base.
        ack_delay = 0;
        mtvec = 32'h1001; mie = 32'h80;
`ifdef TRAP_VECTORED_EN
        push_trap(32'h500, 32'h8000_0007, 32'h0, 32'h1880, 32'h101C);
`else
        push_trap(32'h500, 32'h8000_0007, 32'h0, 32'h1880, 32'h1000);
`endif
        mip = 32'h80; instr_done = 1'b1; next_pc = 32'h500;
        go(0, lat, fl);
        push_trap(32'h600, 32'h4, 32'h601, 32'h1880, 32'h1000);
        exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h600; exc_tval = 32'h601;
        go(0, lat, fl);

        // Reset during W_CAUSE aborts the sequence.
        mtvec = 32'h80;
        push_csr(12'h341, 32'h900);
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h900; exc_tval = 32'h1;
        repeat (3) begin
            @(posedge clk);
            #1;
            clear_reqs();
        end
        chk("mid_w_cause", {20'h0, csr_waddr}, 32'h342);
        resetn = 1'b0;
        #1;
        chk("mid_reset_ctl", {27'h0, flush_req, csr_we, pc_load, busy, trap_taken}, 32'h0);
        chk("mid_reset_data", csr_wdata | pc_target | {20'h0, csr_waddr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset_busy", {31'h0, busy}, 32'h0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
